ssd_scan_driver: RTL

//   Four-digit seven-segment scan driver downstream of the CPU top.

---
 rtl/ssd_scan_driver_if.sv | 13 +
 rtl/ssd_scan_driver.sv | 101 ++++++++++
 2 files changed

// File: rtl/ssd_scan_driver_if.sv
// Display-side bundle of the seven-segment scan driver: value strobe, enable,
// and the active-low segment/anode outputs plus the frame boundary pulse.
interface ssd_scan_driver_if;
  logic [15:0] din;
  logic        din_valid;
  logic        en;
  logic [6:0]  ssd;
  logic [3:0]  a;
  logic        frame_done;

  modport master (output din, din_valid, en, input ssd, a, frame_done);
  modport slave  (input din, din_valid, en, output ssd, a, frame_done);
endinterface

// File: rtl/ssd_scan_driver.sv
// Four-digit hex scan driver; new values take effect only at frame boundaries.
// Define SSD_BLANK_EN to turn on leading-zero blanking of digits 3..1.
module ssd_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  ssd_scan_driver_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [15:0]      pending, pending_nxt;
  logic [15:0]      shadow, shadow_nxt;
  logic [3:0]       a_q, a_nxt;
  logic [6:0]       ssd_q, ssd_nxt;
  logic             frame_done_q;
  logic             tick, boundary, lit;
  logic [3:0]       nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    tick        = (cnt == CNT_MAX);
    boundary    = tick && (idx == 2'd3);
    cnt_nxt     = tick ? '0 : cnt + 1'b1;
    idx_nxt     = tick ? idx + 2'd1 : idx;
    // A strobe coinciding with the boundary goes straight through to shadow.
    pending_nxt = bus.din_valid ? bus.din : pending;
    shadow_nxt  = boundary ? pending_nxt : shadow;
  end

  always_comb begin
    nib = shadow[{idx, 2'b00} +: 4];
`ifdef SSD_BLANK_EN
    case (idx)
      2'd0:    lit = 1'b1;
      2'd1:    lit = |shadow[15:4];
      2'd2:    lit = |shadow[15:8];
      default: lit = |shadow[15:12];
    endcase
`else
    lit = 1'b1;
`endif
    a_nxt   = 4'b1111;
    ssd_nxt = 7'b1111111;
    if (bus.en && lit) begin
      a_nxt   = ~(4'b0001 << idx);
      ssd_nxt = hex7(nib);
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      idx          <= 2'd0;
      pending      <= 16'h0000;
      shadow       <= 16'h0000;
      a_q          <= 4'b1111;
      ssd_q        <= 7'b1111111;
      frame_done_q <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      pending      <= pending_nxt;
      shadow       <= shadow_nxt;
      a_q          <= a_nxt;
      ssd_q        <= ssd_nxt;
      frame_done_q <= boundary;
    end
  end

  assign bus.a          = a_q;
  assign bus.ssd        = ssd_q;
  assign bus.frame_done = frame_done_q;

endmodule
